// File: rtl/alu_pkg.sv
// Shared ALU definitions: negator FSM states and negation mode encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } neg_state_e;

  localparam logic NEG_MODE_ONES = 1'b0;
  localparam logic NEG_MODE_TWOS = 1'b1;

endpackage

// File: rtl/neg_bit_cell.sv
// One-bit negate-and-increment cell: inverts x and adds the incoming carry.
module neg_bit_cell (
  input  logic x,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = ~x ^ cin;
  assign cout = ~x & cin;

endmodule

// File: rtl/serial_negator.sv
// Bit-serial one's/two's complement unit. One operand bit per clock, LSB
// first, through a single neg_bit_cell; result handed off over valid/ready.
module serial_negator
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_neg,
  output logic             out_zero,
  output logic             out_ovf
);

  // Most negative value: the only operand whose two's complement overflows.
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  neg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_q;
  logic             mode_q;
  logic             min_q;
  logic             zero_q;
  logic             ovf_q;
  logic             bit_s;
  logic             bit_c;
  logic             last;
  logic             accept;

  neg_bit_cell u_cell (
    .x    (sr_q[0]),
    .cin  (carry_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign res_nxt = {bit_s, res_q[WIDTH-1:1]};
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/output decode; results are only exposed in DONE.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_neg   = '0;
    out_zero  = 1'b0;
    out_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_neg   = res_q;
        out_zero  = zero_q;
        out_ovf   = ovf_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per cycle, capture flags on the
  // final bit. The overflow flag comes from the operand as loaded, since the
  // shift register no longer holds it by the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      min_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_q    <= in_a;
            mode_q  <= in_mode;
            carry_q <= in_mode;
            min_q   <= (in_a == MIN_VAL);
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        SHIFT: begin
          sr_q    <= sr_q >> 1;
          res_q   <= res_nxt;
          carry_q <= bit_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            zero_q <= (res_nxt == '0);
            ovf_q  <= (mode_q == NEG_MODE_TWOS) && min_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negator.sv
// Directed bench for serial_negator at WIDTH=4.
module tb_serial_negator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_neg;
  logic         out_zero;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  serial_negator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand over one operand, then count cycles until out_valid and check result.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic mode,
                       input logic [W-1:0] exp_neg, input logic exp_zero,
                       input logic exp_ovf, input logic rdy);
    int n;
    @(negedge clk);
    out_ready = rdy;
    in_valid  = 1'b1;
    in_a      = a;
    in_mode   = mode;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_acc_to"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = ~mode;
    chk({tag, "_shift_neg"}, 32'(out_neg), 32'd0);
    chk({tag, "_shift_rdy"}, 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
    chk({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    if (rdy) begin
      @(negedge clk);
      chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_a = 4'b0011; in_mode = 1'b1; out_ready = 1'b1;

    // Reset with in_valid held: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_neg", 32'(out_neg), 32'd0);
    chk("rst_flags", 32'({out_zero, out_ovf}), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      chk("post_rst_rdy", 32'(in_ready), 32'd1);
    end

    do_op("twos_3",   4'b0011, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1);
    do_op("twos_0",   4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    do_op("twos_min", 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1);
    do_op("ones_5",   4'b0101, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1);
    do_op("ones_f",   4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    do_op("ones_min", 4'b1000, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold DONE with a new operand pending.
    do_op("bp", 4'b0011, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = (i % 2 == 0) ? 4'b1001 : 4'b0110;
      in_mode  = 1'b0;
      @(negedge clk);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_neg", 32'(out_neg), 32'h0000000d);
      chk("bp_rdy", 32'(in_ready), 32'd0);
    end
    in_a = 4'b0101; in_mode = 1'b0; out_ready = 1'b1;
    chk("bp_hs_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_rdy", 32'(in_ready), 32'd1);
    chk("bp_next_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_acc", 32'(in_ready), 32'd0);
    begin
      int n;
      n = 1;
      while (!out_valid && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("bp2_lat", n, W + 1);
      chk("bp2_neg", 32'(out_neg), 32'h0000000a);
    end
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts the operation.
    in_valid = 1'b1; in_a = 4'b0111; in_mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ab_shift1", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_rdy", 32'(in_ready), 32'd1);
    chk("ab_vld", 32'(out_valid), 32'd0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("ab_no_vld", 32'(out_valid), 32'd0);
    end
    do_op("ab_next", 4'b0110, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
